// File: rtl/gb_issue_arbiter.sv
// gb_issue_arbiter: round-robin scheduler that shares one gbprocessor between
// NUM_REQ instruction requesters. One instruction is in flight at a time. It is
// pulsed to the processor, and after RESULT_LAT cycles the probe is sampled and
// returned to its owner, tagged with the owner's index.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | accepting: grant the round-robin winner when en=1
//   ISSUE   | proc_valid pulse with the latched instruction; load timer
//   WAIT    | counting down RESULT_LAT cycles of processor latency
//   CAPTURE | sample probe/owner into the response registers
module gb_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int INSTR_W    = 8,
  parameter int PROBE_W    = 32,
  parameter int RESULT_LAT = 2,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [INSTR_W-1:0]         proc_instruction,
  output logic                       proc_valid,
  input  logic [PROBE_W-1:0]         probe,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [PROBE_W-1:0]         rsp_probe,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     owner;
  logic [INSTR_W-1:0]  instr_q;
  logic [3:0]          timer;
  logic [ID_W-1:0]     win_idx;
  logic                win_found;
  logic                grant_ok;

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A grant needs an idle arbiter, enable, a contender, and reset released, so
  // req_ready stays low while reset is held even if requesters are valid.
  always_comb begin
    grant_ok  = (state == IDLE) && en && win_found && reset;
    req_ready = '0;
    if (grant_ok) req_ready[win_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a zero-latency build skips WAIT entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_ok) state_nx = ISSUE;
      ISSUE:   state_nx = (RESULT_LAT == 0) ? CAPTURE : WAIT;
      WAIT:    if (timer == 4'd1) state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: grant latch, latency down-counter and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last      <= ID_W'(NUM_REQ - 1);
      owner     <= '0;
      instr_q   <= '0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_probe <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            instr_q <= req_instr[win_idx*INSTR_W +: INSTR_W];
            owner   <= win_idx;
            last    <= win_idx;
          end
        end
        ISSUE: timer <= 4'(RESULT_LAT);
        WAIT:  timer <= timer - 4'd1;
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= owner;
          rsp_probe <= probe;
        end
        default: ;
      endcase
    end
  end

  // Processor-facing and status outputs; the instruction holds between issues.
  always_comb begin
    proc_valid       = (state == ISSUE);
    proc_instruction = instr_q;
    busy             = (state != IDLE);
  end

endmodule
